// File: rtl/shared_pkg.sv
// ============================================================================
// Module      : shared_pkg
// Description : Default FIFO geometry and the data word type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shared_pkg;

    localparam int FIFO_WIDTH = 16;
    localparam int FIFO_DEPTH = 8;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);

    typedef logic [FIFO_WIDTH-1:0] fifo_data_t;

endpackage : shared_pkg

`default_nettype wire

// File: rtl/fifo_sync.sv
// ============================================================================
// Module      : fifo_sync
// Description : Single-clock FIFO with registered handshake flags and
//               count-derived status flags. Define FIFO_SVA_EN to compile
//               the embedded assertions and cover properties.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_sync #(
    parameter int FIFO_WIDTH = shared_pkg::FIFO_WIDTH,
    parameter int FIFO_DEPTH = shared_pkg::FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  full,
    output logic                  almostfull,
    output logic                  empty,
    output logic                  almostempty
);

    localparam int                PTR_W        = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]    C_CNT_FULL   = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]    C_CNT_AFULL  = (PTR_W+1)'(FIFO_DEPTH - 1);
    localparam logic [PTR_W:0]    C_CNT_ONE    = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0]  C_PTR_ONE    = PTR_W'(1);

    logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W:0]        r_count;
    logic [FIFO_WIDTH-1:0] r_data_out;
    logic                  r_wr_ack;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_acc;
    logic                  w_rd_acc;

    assign w_full   = (r_count == C_CNT_FULL);
    assign w_empty  = (r_count == '0);
    // Acceptance is judged on the pre-edge count, so a write into an empty
    // FIFO is never forwarded to a same-cycle read.
    assign w_wr_acc = wr_en && !w_full;
    assign w_rd_acc = rd_en && !w_empty;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_data_out  <= '0;
            r_wr_ack    <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_wr_ack    <= w_wr_acc;
            r_overflow  <= wr_en && w_full;
            r_underflow <= rd_en && w_empty;

            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end

            if (w_rd_acc) begin
                r_data_out <= r_mem[r_rd_ptr];
                r_rd_ptr   <= r_rd_ptr + C_PTR_ONE;
            end

            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + C_CNT_ONE;
                2'b01:   r_count <= r_count - C_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign data_out    = r_data_out;
    assign wr_ack      = r_wr_ack;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;
    assign full        = w_full;
    assign empty       = w_empty;
    assign almostfull  = (r_count == C_CNT_AFULL);
    assign almostempty = (r_count == C_CNT_ONE);

`ifdef FIFO_SVA_EN
    a_count_bound: assert property (@(posedge clk) disable iff (rst)
        r_count <= C_CNT_FULL);

    a_full_empty_excl: assert property (@(posedge clk) disable iff (rst)
        !(w_full && w_empty));

    a_overflow_src: assert property (@(posedge clk) disable iff (rst)
        r_overflow |-> $past(w_full));

    a_underflow_src: assert property (@(posedge clk) disable iff (rst)
        r_underflow |-> $past(w_empty));

    a_ack_ovf_excl: assert property (@(posedge clk) disable iff (rst)
        !(r_wr_ack && r_overflow));

    a_wr_ptr_inc: assert property (@(posedge clk) disable iff (rst)
        w_wr_acc |=> (r_wr_ptr == $past(r_wr_ptr) + C_PTR_ONE));

    always_comb begin
        if (rst) begin
            a_rst_empty: assert (w_empty);
        end
    end

    c_full: cover property (@(posedge clk) disable iff (rst) w_full);

    c_wr_wrap: cover property (@(posedge clk) disable iff (rst)
        w_wr_acc && (r_wr_ptr == PTR_W'(FIFO_DEPTH - 1)));

    c_rd_wrap: cover property (@(posedge clk) disable iff (rst)
        w_rd_acc && (r_rd_ptr == PTR_W'(FIFO_DEPTH - 1)));

    c_rw_afull: cover property (@(posedge clk) disable iff (rst)
        wr_en && rd_en && (r_count == C_CNT_AFULL));
`endif

endmodule : fifo_sync

`default_nettype wire

// File: tb/tb_fifo_sync.sv
// ============================================================================
// Module      : tb_fifo_sync
// Description : Directed and randomized checks of fifo_sync against a
//               queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_sync;
    import shared_pkg::*;

    localparam int D = FIFO_DEPTH;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic       rd_en;
    fifo_data_t data_in;
    fifo_data_t data_out;
    logic       wr_ack, overflow, underflow;
    logic       full, almostfull, empty, almostempty;

    int tests = 0;
    int fails = 0;

    fifo_data_t q[$];
    fifo_data_t m_dout;
    logic       m_ack, m_ovf, m_udf;

    always #5 clk = ~clk;

    fifo_sync #(.FIFO_WIDTH(FIFO_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .data_out   (data_out),
        .wr_ack     (wr_ack),
        .overflow   (overflow),
        .underflow  (underflow),
        .full       (full),
        .almostfull (almostfull),
        .empty      (empty),
        .almostempty(almostempty)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, "/data_out"},    32'(data_out),    32'(m_dout));
        chk({ctx, "/wr_ack"},      32'(wr_ack),      32'(m_ack));
        chk({ctx, "/overflow"},    32'(overflow),    32'(m_ovf));
        chk({ctx, "/underflow"},   32'(underflow),   32'(m_udf));
        chk({ctx, "/full"},        32'(full),        32'(q.size() == D));
        chk({ctx, "/almostfull"},  32'(almostfull),  32'(q.size() == D - 1));
        chk({ctx, "/empty"},       32'(empty),       32'(q.size() == 0));
        chk({ctx, "/almostempty"}, 32'(almostempty), 32'(q.size() == 1));
    endtask

    // Called at a negedge: drive, let one posedge pass, update model, check.
    task automatic step(input string ctx, input logic w, input logic r, input fifo_data_t d);
        logic was_full, was_empty;
        wr_en   = w;
        rd_en   = r;
        data_in = d;
        @(posedge clk);
        was_full  = (q.size() == D);
        was_empty = (q.size() == 0);
        m_ack = w && !was_full;
        m_ovf = w && was_full;
        m_udf = r && was_empty;
        if (r && !was_empty) m_dout = q.pop_front();
        if (w && !was_full)  q.push_back(d);
        @(negedge clk);
        check_all(ctx);
    endtask

    // Reset asserted between edges; outputs must clear without a clock.
    task automatic mid_reset(input string ctx);
        wr_en = 1'b0;
        rd_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        q.delete();
        m_dout = '0;
        m_ack  = 1'b0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
        check_all({ctx, "_async"});
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        data_in = '0;
        m_dout  = '0;
        m_ack   = 1'b0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_all("reset");
        rst = 1'b0;

        // Reset mid-stream
        for (int i = 0; i < 3; i++) step("pre_rst_wr", 1'b1, 1'b0, fifo_data_t'(16'h0100 + i));
        mid_reset("rst_mid");
        step("post_rst_rd", 1'b0, 1'b1, '0);
        step("post_rst_idle", 1'b0, 1'b0, '0);

        // Fill to full, then one extra write
        for (int i = 1; i <= D; i++) step("fill", 1'b1, 1'b0, fifo_data_t'(i));
        step("fill_ovf", 1'b1, 1'b0, 16'hDEAD);
        chk("fill_ovf_hold_full", 32'(full), 32'd1);

        // Drain in order, then one extra read
        for (int i = 1; i <= D; i++) begin
            step("drain", 1'b0, 1'b1, '0);
            chk("drain_order", 32'(data_out), 32'(i));
        end
        step("drain_udf", 1'b0, 1'b1, '0);
        chk("drain_udf_hold", 32'(data_out), 32'h0008);

        // Simultaneous on empty
        step("rw_empty", 1'b1, 1'b1, 16'hABCD);
        chk("rw_empty_dout", 32'(data_out), 32'h0008);

        // Top up to full, then simultaneous on full
        for (int i = 0; i < D - 1; i++) step("topup", 1'b1, 1'b0, fifo_data_t'(16'h2000 + i));
        step("rw_full", 1'b1, 1'b1, 16'h5555);
        chk("rw_full_oldest", 32'(data_out), 32'hABCD);

        // Down to count 4, then streaming write+read wraps both pointers
        for (int i = 0; i < 3; i++) step("to4", 1'b0, 1'b1, '0);
        for (int i = 0; i < 20; i++) step("wrap", 1'b1, 1'b1, fifo_data_t'(16'h3000 + i));
        chk("wrap_dout", 32'(data_out), 32'h3000 + 32'd15);

        // Randomized phases biased toward filling, draining and mixing
        for (int p = 0; p < 6; p++) begin
            int wp, rp;
            wp = (p % 3 == 0) ? 80 : (p % 3 == 1) ? 20 : 50;
            rp = 100 - wp;
            if (p == 3) mid_reset("rst_rand");
            for (int i = 0; i < 60; i++) begin
                step("rand",
                     ($urandom_range(0, 99) < wp),
                     ($urandom_range(0, 99) < rp),
                     fifo_data_t'($urandom));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_fifo_sync

`default_nettype wire
